// File: rtl/txt_load_feeder.sv
// txt_load_feeder: buffers ioctl TXT downloads in a small FIFO, folds line endings to CR and
// replays bytes through a paced valid/ready port. Define TXT_LOADER_UPCASE_EN to fold a-z to A-Z.

module txt_load_feeder #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [7:0]  TXT_INDEX  = 8'd1,
  parameter int unsigned CHAR_GAP   = 48000,
  parameter int unsigned LINE_GAP   = 480000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        enable,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] byte_count
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W   = DEPTH_LOG2 + 1;
  localparam int unsigned GAP_MAX = (LINE_GAP > CHAR_GAP) ? LINE_GAP : CHAR_GAP;
  localparam int unsigned GAP_W   = (GAP_MAX > 2) ? $clog2(GAP_MAX) : 1;

  localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LVL  = CNT_W'(DEPTH - 2);
  localparam logic [GAP_W-1:0] CHAR_LOAD = GAP_W'(CHAR_GAP - 1);
  localparam logic [GAP_W-1:0] LINE_LOAD = GAP_W'(LINE_GAP - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [GAP_W-1:0]      gap_cnt, gap_next;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  last_cr;
  logic                  dl_prev;

  logic                  dl_rise;
  logic                  accept;
  logic                  is_cr, is_lf;
  logic                  drop_lf;
  logic                  full;
  logic                  push, pop;
  logic [7:0]            wr_byte;
  logic [7:0]            head;

  // The file offset carries no information for a serial replay.
  logic                  addr_unused;
  assign addr_unused = ^ioctl_addr;

  assign dl_rise = ioctl_download & ~dl_prev;
  assign accept  = ioctl_download & ioctl_wr & enable & (ioctl_index == TXT_INDEX);
  assign is_cr   = (ioctl_data == 8'h0D);
  assign is_lf   = (ioctl_data == 8'h0A);
  // last_cr belongs to the previous download until the rising-edge clear lands.
  assign drop_lf = is_lf & last_cr & ~dl_rise;
  assign full    = (count == FULL_LVL);
  assign push    = accept & ~drop_lf & ~full;
  assign pop     = (state == PRESENT) & rx_ready;
  assign head    = mem[rd_ptr];

  always_comb begin
`ifdef TXT_LOADER_UPCASE_EN
    wr_byte = (ioctl_data >= 8'h61 && ioctl_data <= 8'h7A) ? (ioctl_data - 8'h20) : ioctl_data;
`else
    wr_byte = ioctl_data;
`endif
    if (is_lf) wr_byte = 8'h0D;
  end

  // NOTE: storage array has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= wr_byte;
  end

  // NOTE: all state here uses <= so every register samples pre-edge values of its peers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ioctl_wait <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
      last_cr    <= 1'b0;
      dl_prev    <= 1'b0;
    end else begin
      dl_prev <= ioctl_download;

      if (!enable) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      ioctl_wait <= enable & (count >= WAIT_LVL);

      if (dl_rise)
        overflow <= 1'b0;
      else if (accept & ~drop_lf & full)
        overflow <= 1'b1;

      if (dl_rise)
        byte_count <= {15'd0, pop};
      else if (pop)
        byte_count <= byte_count + 16'd1;

      if (accept)
        last_cr <= is_cr;
      else if (dl_rise | ~enable)
        last_cr <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    rx_valid   = 1'b0;

    unique case (state)
      IDLE: begin
        if (count != '0) state_next = PRESENT;
      end
      PRESENT: begin
        rx_valid = 1'b1;
        if (rx_ready) begin
          gap_next   = (head == 8'h0D) ? LINE_LOAD : CHAR_LOAD;
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0)
          state_next = IDLE;
        else
          gap_next = gap_cnt - 1'b1;
      end
      default: state_next = IDLE;
    endcase

    // Leaving File mode abandons whatever was in flight.
    if (!enable) begin
      state_next = IDLE;
      gap_next   = '0;
    end
  end

  assign rx_data = rx_valid ? head : 8'h00;
  assign busy    = ioctl_download | (count != '0) | (state != IDLE);

endmodule
